mem_bridge: RTL and testbench

Memory-side responder for the core's two word-wide request ports (instruction fetch, data load/store). It serves both ports from a single 64-bit physical-memory port: it arbitrates between the two ports, issues single-beat doubleword accesses, and performs read-modify-write for byte-masked stores. It sits between the `mp4` core ports and `pmem`, and replaces the direct memory hookup used before CP2.

---
 rtl/rv32i_types.sv | 26 ++
 rtl/dword_merge.sv | 21 ++
 rtl/mem_bridge.sv | 191 +++++++++++++++++++
 tb/tb_mem_bridge.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the memory bridge: FSM state and requester identity,
// plus small doubleword helpers used by the bridge datapath.
package rv32i_types;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    RMW_WR,
    DONE
  } mem_bridge_state_t;

  typedef enum logic {
    REQ_INSTR,
    REQ_DATA
  } mem_req_t;

  function automatic logic [31:0] dword_select(input logic [63:0] dw, input logic hi);
    return hi ? dw[63:32] : dw[31:0];
  endfunction

  function automatic logic [31:0] dword_align(input logic [31:0] addr);
    return {addr[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/dword_merge.sv
// Byte-masked insertion of a 32-bit word into one half of a 64-bit doubleword.
module dword_merge (
  input  logic [63:0] dw_i,
  input  logic [31:0] word_i,
  input  logic [3:0]  mbe_i,
  input  logic        sel_i,
  output logic [63:0] dw_o
);

  logic [31:0] bmask;
  logic [31:0] lo_merged;
  logic [31:0] hi_merged;

  assign bmask = {{8{mbe_i[3]}}, {8{mbe_i[2]}}, {8{mbe_i[1]}}, {8{mbe_i[0]}}};

  assign lo_merged = (dw_i[31:0]  & ~bmask) | (word_i & bmask);
  assign hi_merged = (dw_i[63:32] & ~bmask) | (word_i & bmask);

  assign dw_o = sel_i ? {hi_merged, dw_i[31:0]} : {dw_i[63:32], lo_merged};

endmodule

// File: rtl/mem_bridge.sv
// Serves instruction and data word ports from one 64-bit pmem port, with RMW for byte-masked stores.
// Optional doubleword line buffer enabled by defining MEM_BRIDGE_LINEBUF_EN.
module mem_bridge
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic        instr_read,
  input  logic [31:0] instr_mem_address,
  output logic        instr_mem_resp,
  output logic [31:0] instr_mem_rdata,

  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_mbe,
  input  logic [31:0] data_mem_address,
  input  logic [31:0] data_mem_wdata,
  output logic        data_mem_resp,
  output logic [31:0] data_mem_rdata,

  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [63:0] pmem_wdata,
  input  logic        pmem_resp,
  input  logic [63:0] pmem_rdata
);

  mem_bridge_state_t state_q;
  mem_req_t          req_q;
  logic              wsel_q;
  logic [3:0]        mbe_q;
  logic [31:0]       wdata_q;

  logic              pmem_read_q;
  logic              pmem_write_q;
  logic [31:0]       pmem_address_q;
  logic [63:0]       pmem_wdata_q;
  logic              instr_resp_q;
  logic              data_resp_q;
  logic [31:0]       instr_rdata_q;
  logic [31:0]       data_rdata_q;

`ifdef MEM_BRIDGE_LINEBUF_EN
  logic              valid_q;
  logic [28:0]       tag_q;
  logic [63:0]       buf_q;
`endif

  logic              data_req;
  logic [31:0]       req_addr;
  logic [63:0]       merged_dw;
  logic              unused_addr_bits;

  // Data port has fixed priority over instruction fetch.
  assign data_req         = data_read | data_write;
  assign req_addr         = data_req ? data_mem_address : instr_mem_address;
  assign unused_addr_bits = ^req_addr[1:0];

  dword_merge u_merge (
    .dw_i   (pmem_rdata),
    .word_i (wdata_q),
    .mbe_i  (mbe_q),
    .sel_i  (wsel_q),
    .dw_o   (merged_dw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      req_q          <= REQ_INSTR;
      wsel_q         <= 1'b0;
      mbe_q          <= 4'b0000;
      wdata_q        <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      instr_resp_q   <= 1'b0;
      data_resp_q    <= 1'b0;
      instr_rdata_q  <= '0;
      data_rdata_q   <= '0;
`ifdef MEM_BRIDGE_LINEBUF_EN
      valid_q        <= 1'b0;
      tag_q          <= '0;
      buf_q          <= '0;
`endif
    end else begin
      instr_resp_q <= 1'b0;
      data_resp_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_req || instr_read) begin
            req_q          <= data_req ? REQ_DATA : REQ_INSTR;
            wsel_q         <= req_addr[2];
            mbe_q          <= data_mbe;
            wdata_q        <= data_mem_wdata;
            pmem_address_q <= dword_align(req_addr);
            if (data_write) begin
              // A store with no enabled bytes changes nothing in memory.
              if (data_mbe == 4'b0000) begin
                data_resp_q <= 1'b1;
                state_q     <= DONE;
              end else begin
                pmem_read_q <= 1'b1;
                state_q     <= RMW_RD;
              end
            end
`ifdef MEM_BRIDGE_LINEBUF_EN
            else if (valid_q && (tag_q == req_addr[31:3])) begin
              if (data_req) begin
                data_resp_q  <= 1'b1;
                data_rdata_q <= dword_select(buf_q, req_addr[2]);
              end else begin
                instr_resp_q  <= 1'b1;
                instr_rdata_q <= dword_select(buf_q, req_addr[2]);
              end
              state_q <= DONE;
            end
`endif
            else begin
              pmem_read_q <= 1'b1;
              state_q     <= RD;
            end
          end
        end

        RD: begin
          if (pmem_resp) begin
            pmem_read_q <= 1'b0;
            if (req_q == REQ_DATA) begin
              data_resp_q  <= 1'b1;
              data_rdata_q <= dword_select(pmem_rdata, wsel_q);
            end else begin
              instr_resp_q  <= 1'b1;
              instr_rdata_q <= dword_select(pmem_rdata, wsel_q);
            end
`ifdef MEM_BRIDGE_LINEBUF_EN
            buf_q   <= pmem_rdata;
            tag_q   <= pmem_address_q[31:3];
            valid_q <= 1'b1;
`endif
            state_q <= DONE;
          end
        end

        RMW_RD: begin
          if (pmem_resp) begin
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b1;
            pmem_wdata_q <= merged_dw;
            state_q      <= RMW_WR;
          end
        end

        RMW_WR: begin
          if (pmem_resp) begin
            pmem_write_q <= 1'b0;
            data_resp_q  <= 1'b1;
            data_rdata_q <= dword_select(pmem_wdata_q, wsel_q);
`ifdef MEM_BRIDGE_LINEBUF_EN
            buf_q   <= pmem_wdata_q;
            tag_q   <= pmem_address_q[31:3];
            valid_q <= 1'b1;
`endif
            state_q <= DONE;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign instr_mem_resp  = instr_resp_q;
  assign instr_mem_rdata = instr_rdata_q;
  assign data_mem_resp   = data_resp_q;
  assign data_mem_rdata  = data_rdata_q;
  assign pmem_read       = pmem_read_q;
  assign pmem_write      = pmem_write_q;
  assign pmem_address    = pmem_address_q;
  assign pmem_wdata      = pmem_wdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: pmem model with programmable latency, response scoreboard.
module tb_mem_bridge;

  logic        clk;
  logic        rst;
  logic        instr_read;
  logic [31:0] instr_mem_address;
  logic        instr_mem_resp;
  logic [31:0] instr_mem_rdata;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_mbe;
  logic [31:0] data_mem_address;
  logic [31:0] data_mem_wdata;
  logic        data_mem_resp;
  logic [31:0] data_mem_rdata;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic        pmem_resp;
  logic [63:0] pmem_rdata;

  mem_bridge dut (
    .clk               (clk),
    .rst               (rst),
    .instr_read        (instr_read),
    .instr_mem_address (instr_mem_address),
    .instr_mem_resp    (instr_mem_resp),
    .instr_mem_rdata   (instr_mem_rdata),
    .data_read         (data_read),
    .data_write        (data_write),
    .data_mbe          (data_mbe),
    .data_mem_address  (data_mem_address),
    .data_mem_wdata    (data_mem_wdata),
    .data_mem_resp     (data_mem_resp),
    .data_mem_rdata    (data_mem_rdata),
    .pmem_read         (pmem_read),
    .pmem_write        (pmem_write),
    .pmem_address      (pmem_address),
    .pmem_wdata        (pmem_wdata),
    .pmem_resp         (pmem_resp),
    .pmem_rdata        (pmem_rdata)
  );

  typedef struct {
    bit          is_data;
    bit          chk;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] wdata;
  } op_t;

  exp_t        exp_q[$];
  op_t         op_q[$];
  logic [63:0] mem [logic [28:0]];

  int tests = 0;
  int fails = 0;
  int pmem_lat = 1;
  int resp_cnt = 0;
  int strobe_cycles = 0;
  int pmem_ops = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input logic [31:0] addr, input logic [63:0] val);
    mem[addr[31:3]] = val;
  endtask

  task automatic exp_rd(input logic [31:0] addr);
    op_q.push_back('{wr: 1'b0, addr: addr, wdata: 64'h0});
  endtask

  task automatic exp_wr(input logic [31:0] addr, input logic [63:0] wd);
    op_q.push_back('{wr: 1'b1, addr: addr, wdata: wd});
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_instr_resp"},  64'(instr_mem_resp),  64'd0);
    check({tag, "_instr_rdata"}, 64'(instr_mem_rdata), 64'd0);
    check({tag, "_data_resp"},   64'(data_mem_resp),   64'd0);
    check({tag, "_data_rdata"},  64'(data_mem_rdata),  64'd0);
    check({tag, "_pmem_read"},   64'(pmem_read),       64'd0);
    check({tag, "_pmem_write"},  64'(pmem_write),      64'd0);
    check({tag, "_pmem_addr"},   64'(pmem_address),    64'd0);
    check({tag, "_pmem_wdata"},  pmem_wdata,           64'd0);
  endtask

  // Issue one request, measure response latency from the accept cycle, then drop it.
  task automatic do_req(input bit is_data, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] mbe, input bit chk,
                        input logic [31:0] exp_rdata, input int exp_lat, input string tag);
    int lat;
    exp_q.push_back('{is_data: is_data, chk: chk, rdata: exp_rdata});
    @(posedge clk); #1;
    if (is_data) begin
      data_read        = ~wr;
      data_write       = wr;
      data_mem_address = addr;
      data_mem_wdata   = wd;
      data_mbe         = mbe;
    end else begin
      instr_read        = 1'b1;
      instr_mem_address = addr;
    end
    lat = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (is_data ? data_mem_resp : instr_mem_resp) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    @(posedge clk); #1;
    instr_read = 1'b0;
    data_read  = 1'b0;
    data_write = 1'b0;
    check({tag, "_pulse"}, 64'(is_data ? data_mem_resp : instr_mem_resp), 64'd0);
  endtask

  // pmem model: answers each strobe after pmem_lat cycles and checks it against op_q.
  initial begin : pmem_model
    int          cnt;
    op_t         e;
    logic [28:0] line;
    cnt        = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = 64'h0;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (!rst && (pmem_read || pmem_write)) begin
        if (cnt >= pmem_lat) begin
          cnt       = 0;
          pmem_resp = 1'b1;
          pmem_ops++;
          line = pmem_address[31:3];
          if (op_q.size() != 0) begin
            e = op_q.pop_front();
          end else begin
            e.wr    = 1'b0;
            e.addr  = 32'hFFFF_FFFF;
            e.wdata = 64'h0;
          end
          check("pmem_op_write", 64'(pmem_write), 64'(e.wr));
          check("pmem_op_addr", 64'(pmem_address), 64'(e.addr));
          if (pmem_write) begin
            check("pmem_op_wdata", pmem_wdata, e.wdata);
            mem[line] = pmem_wdata;
          end else begin
            pmem_rdata = mem.exists(line) ? mem[line] : 64'h0;
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : resp_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (pmem_read || pmem_write) begin
        strobe_cycles++;
        check("pmem_strobe_excl", 64'(pmem_read & pmem_write), 64'd0);
      end
      if (instr_mem_resp || data_mem_resp) begin
        resp_cnt++;
        check("resp_onehot", 64'(instr_mem_resp & data_mem_resp), 64'd0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
        end else begin
          e.is_data = ~data_mem_resp;
          e.chk     = 1'b0;
          e.rdata   = 32'h0;
        end
        check("resp_port", 64'(data_mem_resp), 64'(e.is_data));
        if (e.chk)
          check("resp_rdata", 64'(data_mem_resp ? data_mem_rdata : instr_mem_rdata), 64'(e.rdata));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    int s0;
    int r0;
    int o0;
    rst               = 1'b1;
    instr_read        = 1'b0;
    instr_mem_address = 32'h0;
    data_read         = 1'b0;
    data_write        = 1'b0;
    data_mbe          = 4'h0;
    data_mem_address  = 32'h0;
    data_mem_wdata    = 32'h0;

    set_mem(32'h060, 64'h1111_2222_3333_4444);
    set_mem(32'h040, 64'h0BAD_F00D_1234_5678);
    set_mem(32'h080, 64'hDEAD_BEEF_CAFE_F00D);
    set_mem(32'h100, 64'h0123_4567_89AB_CDEF);
    set_mem(32'h108, 64'h0011_2233_4455_6677);
    set_mem(32'h500, 64'h5555_5555_5555_5555);
    set_mem(32'h600, 64'h6666_0000_9999_1111);
    set_mem(32'h200, 64'hCCCC_DDDD_AAAA_BBBB);

    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_zero("rst_release");

    // Fetch with pmem answering in cycle 3: resp in cycle 4.
    pmem_lat = 2;
    exp_rd(32'h0000_0060);
    do_req(1'b0, 1'b0, 32'h0000_0064, 32'h0, 4'h0, 1'b1, 32'h1111_2222, 4, "fetch_64");

    // Simultaneous fetch and load: data first, fetch stays pending.
    pmem_lat = 1;
    exp_q.push_back('{is_data: 1'b1, chk: 1'b1, rdata: 32'hCAFE_F00D});
    exp_q.push_back('{is_data: 1'b0, chk: 1'b1, rdata: 32'h1234_5678});
    exp_rd(32'h0000_0080);
    exp_rd(32'h0000_0040);
    @(posedge clk); #1;
    instr_read        = 1'b1;
    instr_mem_address = 32'h0000_0040;
    data_read         = 1'b1;
    data_mem_address  = 32'h0000_0080;
    lat = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (data_mem_resp) begin
        lat = n;
        break;
      end
    end
    check("simul_data_latency", 64'(lat), 64'd3);
    check("simul_instr_waits", 64'(instr_mem_resp), 64'd0);
    @(posedge clk); #1;
    data_read = 1'b0;
    lat = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (instr_mem_resp) begin
        lat = n;
        break;
      end
    end
    check("simul_instr_latency", 64'(lat), 64'd3);
    @(posedge clk); #1;
    instr_read = 1'b0;

    // Byte-masked stores into each half of a doubleword, then read back.
    exp_rd(32'h0000_0108);
    exp_wr(32'h0000_0108, 64'h5511_2233_4455_6677);
    do_req(1'b1, 1'b1, 32'h0000_010C, 32'h5500_0000, 4'b1000, 1'b0, 32'h0, 5, "store_10c_hi");
    exp_rd(32'h0000_0100);
    exp_wr(32'h0000_0100, 64'h0123_4567_89BB_CDDD);
    do_req(1'b1, 1'b1, 32'h0000_0100, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0, 5, "store_100");
    exp_rd(32'h0000_0108);
    do_req(1'b1, 1'b0, 32'h0000_010C, 32'h0, 4'h0, 1'b1, 32'h5511_2233, 3, "load_10c");

    // Zero-mask store: immediate resp, no pmem strobes.
    s0 = strobe_cycles;
    do_req(1'b1, 1'b1, 32'h0000_0300, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0, 1, "store_mbe0");
    check("store_mbe0_no_pmem", 64'(strobe_cycles), 64'(s0));

    // Reset while a read is outstanding.
    pmem_lat = 10;
    @(posedge clk); #1;
    instr_read        = 1'b1;
    instr_mem_address = 32'h0000_0500;
    repeat (3) @(posedge clk);
    #3;
    check("rd_before_rst_pmem_read", 64'(pmem_read), 64'd1);
    r0  = resp_cnt;
    o0  = pmem_ops;
    rst = 1'b1;
    #1;
    check("rst_mid_rd_pmem_read", 64'(pmem_read), 64'd0);
    chk_zero("rst_mid_rd");
    instr_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("rst_mid_rd_no_resp", 64'(resp_cnt), 64'(r0));
    check("rst_mid_rd_no_pmem_op", 64'(pmem_ops), 64'(o0));

    // Normal operation after reset, zero-latency memory.
    pmem_lat = 0;
    exp_rd(32'h0000_0600);
    do_req(1'b0, 1'b0, 32'h0000_0600, 32'h0, 4'h0, 1'b1, 32'h9999_1111, 2, "fetch_after_rst");

`ifdef MEM_BRIDGE_LINEBUF_EN
    pmem_lat = 1;
    exp_rd(32'h0000_0200);
    do_req(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 1'b1, 32'hAAAA_BBBB, 3, "lb_fetch_200");
    s0 = strobe_cycles;
    do_req(1'b0, 1'b0, 32'h0000_0204, 32'h0, 4'h0, 1'b1, 32'hCCCC_DDDD, 1, "lb_fetch_204_hit");
    check("lb_hit_no_pmem", 64'(strobe_cycles), 64'(s0));
    exp_rd(32'h0000_0200);
    exp_wr(32'h0000_0200, 64'h7777_8888_AAAA_BBBB);
    do_req(1'b1, 1'b1, 32'h0000_0204, 32'h7777_8888, 4'b1111, 1'b0, 32'h0, 5, "lb_store_204");
    do_req(1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'h0, 1'b1, 32'h7777_8888, 1, "lb_load_204_hit");
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("pmem_ops_drained", 64'(op_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
